// File: rtl/unlock_sequencer.sv
// rtl/unlock_sequencer.sv - key sequence unlock controller driving the shared key comparator
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   key_in/key_valid      candidate key byte and its valid strobe
//   key_ready             high only in IDLE; a byte is taken on key_valid & key_ready
//   relock                in UNLOCKED, return to IDLE
//   match_key             registered byte presented to the comparator
//   match_unlock          comparator unlock vector, one bit per sequence position
//   progress              correct bytes in the current attempt
//   fail_count            consecutive failed attempts
//   key_err               one-cycle pulse after a mismatch
//   lockout/blocked/unlocked  registered state decodes, mutually exclusive
module unlock_sequencer #(
   parameter int SEQ_LEN        = 19,
   parameter int LOCKOUT_CYCLES = 16,
   parameter int MAX_FAILS      = 3,
   localparam int PW = $clog2(SEQ_LEN + 1),
   localparam int FW = $clog2(MAX_FAILS + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         key_in,
   input  logic               key_valid,
   output logic               key_ready,
   input  logic               relock,
   output logic [7:0]         match_key,
   input  logic [SEQ_LEN-1:0] match_unlock,
   output logic [PW-1:0]      progress,
   output logic [FW-1:0]      fail_count,
   output logic               key_err,
   output logic               lockout,
   output logic               blocked,
   output logic               unlocked
);

   localparam int CW = $clog2(LOCKOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_LOCKOUT,
      S_BLOCKED,
      S_UNLOCKED
   } state_t;

   state_t         state, state_n;
   logic [7:0]     match_key_n;
   logic [PW-1:0]  progress_n;
   logic [FW-1:0]  fail_count_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic           key_err_n;
   logic           hit;

   assign key_ready = (state == S_IDLE);

   // Only the bit for the current position counts; a byte that is valid
   // elsewhere in the sequence is still a miss here.
   assign hit = match_unlock[progress];

   always_comb begin
      state_n      = state;
      match_key_n  = match_key;
      progress_n   = progress;
      fail_count_n = fail_count;
      cnt_n        = cnt;
      key_err_n    = 1'b0;
      case (state)
         S_IDLE: begin
            if (key_valid) begin
               match_key_n = key_in;
               state_n     = S_CHECK;
            end
         end
         S_CHECK: begin
            if (hit) begin
               if (progress == PW'(SEQ_LEN - 1)) begin
                  progress_n   = PW'(SEQ_LEN);
                  fail_count_n = '0;
                  state_n      = S_UNLOCKED;
               end else begin
                  progress_n = progress + PW'(1);
                  state_n    = S_IDLE;
               end
            end else begin
               key_err_n  = 1'b1;
               progress_n = '0;
               if (fail_count == FW'(MAX_FAILS - 1)) begin
                  fail_count_n = FW'(MAX_FAILS);
                  state_n      = S_BLOCKED;
               end else begin
                  fail_count_n = fail_count + FW'(1);
                  cnt_n        = CW'(LOCKOUT_CYCLES);
                  state_n      = S_LOCKOUT;
               end
            end
         end
         S_LOCKOUT: begin
            // Counter is loaded with LOCKOUT_CYCLES on entry and leaves at 1,
            // giving exactly LOCKOUT_CYCLES cycles of residency.
            if (cnt == CW'(1)) begin
               cnt_n   = '0;
               state_n = S_IDLE;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         S_BLOCKED: begin
            state_n = S_BLOCKED;
         end
         S_UNLOCKED: begin
            if (relock) begin
               progress_n = '0;
               state_n    = S_IDLE;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         match_key  <= '0;
         progress   <= '0;
         fail_count <= '0;
         cnt        <= '0;
         key_err    <= 1'b0;
         lockout    <= 1'b0;
         blocked    <= 1'b0;
         unlocked   <= 1'b0;
      end else begin
         state      <= state_n;
         match_key  <= match_key_n;
         progress   <= progress_n;
         fail_count <= fail_count_n;
         cnt        <= cnt_n;
         key_err    <= key_err_n;
         // Decoded from the next state so the flags line up with state.
         lockout    <= (state_n == S_LOCKOUT);
         blocked    <= (state_n == S_BLOCKED);
         unlocked   <= (state_n == S_UNLOCKED);
      end
   end

endmodule

// File: tb/tb_unlock_sequencer.sv
// tb/tb_unlock_sequencer.sv - self-checking bench for unlock_sequencer
module tb_unlock_sequencer;

   localparam logic [7:0] SEQ [19] = '{8'd83, 8'd52, 8'd116, 8'd95, 8'd115, 8'd48, 8'd49,
                                       8'd118, 8'd101, 8'd82, 8'd95, 8'd105, 8'd53, 8'd95,
                                       8'd71, 8'd114, 8'd57, 8'd97, 8'd55};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  key_in = 8'h00;
   logic        key_valid = 1'b0;
   logic        key_ready;
   logic        relock = 1'b0;
   logic [7:0]  match_key;
   logic [18:0] match_unlock;
   logic [4:0]  progress;
   logic [1:0]  fail_count;
   logic        key_err;
   logic        lockout;
   logic        blocked;
   logic        unlocked;

   int total = 0;
   int bad = 0;

   int m_prog = 0;
   int m_fc = 0;

   typedef struct {
      logic [7:0] key;
      int         err;
      int         prog;
      int         fc;
      int         lo;
      int         bl;
      int         un;
   } exp_t;
   exp_t q[$];

   unlock_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_in       (key_in),
      .key_valid    (key_valid),
      .key_ready    (key_ready),
      .relock       (relock),
      .match_key    (match_key),
      .match_unlock (match_unlock),
      .progress     (progress),
      .fail_count   (fail_count),
      .key_err      (key_err),
      .lockout      (lockout),
      .blocked      (blocked),
      .unlocked     (unlocked)
   );

   always #5 clk = ~clk;

   // Comparator model: bit i set when the presented byte equals sequence byte i.
   always_comb begin
      match_unlock = '0;
      for (int i = 0; i < 19; i++) match_unlock[i] = (match_key == SEQ[i]);
   end

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      key_valid = 1'b0;
      relock    = 1'b0;
      rst_n     = 1'b0;
      @(negedge clk);
      rst_n  = 1'b1;
      m_prog = 0;
      m_fc   = 0;
      q.delete();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ready"}, key_ready, 1);
      chk({tag, "_prog"}, progress, 0);
      chk({tag, "_fc"}, fail_count, 0);
      chk({tag, "_lockout"}, lockout, 0);
      chk({tag, "_blocked"}, blocked, 0);
      chk({tag, "_unlocked"}, unlocked, 0);
      chk({tag, "_err"}, key_err, 0);
      chk({tag, "_mkey"}, match_key, 0);
   endtask

   // Offers one byte at the next ready negedge; expectations come from the
   // bench model and are checked two edges later when the CHECK result shows.
   task automatic send(input logic [7:0] b, input bit hold, output int waited);
      exp_t e;
      waited = 0;
      while (!key_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!key_ready) begin
         chk("ready_timeout", 0, 1);
         return;
      end
      key_in    = b;
      key_valid = 1'b1;
      e.key = b;
      if (b == SEQ[m_prog]) begin
         m_prog++;
         if (m_prog == 19) m_fc = 0;
         e.err = 0;
      end else begin
         m_prog = 0;
         m_fc++;
         e.err = 1;
      end
      e.prog = m_prog;
      e.fc   = m_fc;
      e.lo   = (e.err == 1 && m_fc < 3) ? 1 : 0;
      e.bl   = (e.err == 1 && m_fc == 3) ? 1 : 0;
      e.un   = (m_prog == 19) ? 1 : 0;
      q.push_back(e);
      @(negedge clk);
      @(negedge clk);
      if (!hold) key_valid = 1'b0;
      e = q.pop_front();
      chk("mkey", match_key, e.key);
      chk("key_err", key_err, e.err);
      chk("progress", progress, e.prog);
      chk("fail_count", fail_count, e.fc);
      chk("lockout", lockout, e.lo);
      chk("blocked", blocked, e.bl);
      chk("unlocked", unlocked, e.un);
   endtask

   task automatic send_seq(input bit hold);
      int w;
      for (int i = 0; i < 19; i++) begin
         send(SEQ[i], hold, w);
         if (hold && i > 0) chk("stream_gap", w, 0);
      end
      key_valid = 1'b0;
   endtask

   task automatic wait_lockout();
      int n = 0;
      while (lockout && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("lockout_exit", lockout, 0);
   endtask

   task automatic do_relock();
      relock = 1'b1;
      @(negedge clk);
      relock = 1'b0;
      m_prog = 0;
      chk("relock_unlocked", unlocked, 0);
      chk("relock_ready", key_ready, 1);
      chk("relock_prog", progress, 0);
      chk("relock_fc", fail_count, 0);
   endtask

   initial begin
      int w;
      int n;
      int err2;
      int rdy;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk_zero("reset");

      // Full sequence with key_valid held high.
      send_seq(1'b1);
      chk("unl_ready", key_ready, 0);
      chk("unl_fc", fail_count, 0);
      do_relock();

      // Three correct bytes, then a wrong byte; bytes during lockout dropped.
      do_reset();
      for (int i = 0; i < 3; i++) send(SEQ[i], 1'b0, w);
      send(8'h41, 1'b0, w);
      n = 0;
      err2 = -1;
      while (lockout && n < 100) begin
         n++;
         if (n == 2) err2 = key_err;
         key_in    = SEQ[0];
         key_valid = 1'b1;
         @(negedge clk);
      end
      key_valid = 1'b0;
      chk("lockout_len", n, 16);
      chk("err_once", err2, 0);
      chk("after_lo_ready", key_ready, 1);
      chk("dropped_mkey", match_key, 8'h41);
      chk("after_lo_prog", progress, 0);
      chk("after_lo_fc", fail_count, 1);

      // '_' at position 0 is a miss; then two more failures reach BLOCKED.
      do_reset();
      send(8'd95, 1'b0, w);
      wait_lockout();
      send(8'h00, 1'b0, w);
      wait_lockout();
      send(SEQ[0], 1'b0, w);
      send(8'hFF, 1'b0, w);
      rdy = 0;
      key_in    = SEQ[0];
      key_valid = 1'b1;
      relock    = 1'b1;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (key_ready) rdy++;
      end
      key_valid = 1'b0;
      relock    = 1'b0;
      chk("blocked_ready_cnt", rdy, 0);
      chk("blocked_hold", blocked, 1);
      chk("blocked_fc", fail_count, 3);
      do_reset();
      chk_zero("unblock");

      // One failure, then full success clears fail_count; relock and retry.
      send(8'h41, 1'b0, w);
      wait_lockout();
      send_seq(1'b0);
      do_relock();
      send_seq(1'b1);
      chk("retry_unlocked", unlocked, 1);

      // Reset mid-attempt at progress 7.
      do_reset();
      for (int i = 0; i < 7; i++) send(SEQ[i], 1'b0, w);
      chk("mid_prog", progress, 7);
      do_reset();
      chk_zero("mid_reset");

      // Reset during LOCKOUT.
      send(8'h41, 1'b0, w);
      repeat (4) @(negedge clk);
      chk("in_lockout", lockout, 1);
      do_reset();
      chk_zero("lo_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
